// File: rtl/game_tick_sync.sv
// Purpose     : consumer end of the game clock; synchronises the slow game_clock
//               toggle, applies speed scaling/pause/stall watchdog, emits move ticks.
// Latency     : move_tick rises after the 3rd clk edge that samples game_clock high.
// Backpressure: pulse mode has none; with TICK_HANDSHAKE_EN the request holds until
//               move_ack and ticks arriving meanwhile are counted in missed_ticks.
//
// Ports:
//   clk, reset    system clock; asynchronous active-high reset
//   game_clock    slow free-running toggle from the divider (asynchronous)
//   pause         level; suppresses ticks and freezes the skip counter
//   speed_level   0 = tick every 4th game_clock edge .. 3 = every edge
//   move_ack      request acknowledge (only meaningful with TICK_HANDSHAKE_EN)
//   move_tick     move request / pulse to the snake FSM
//   tick_count    ticks issued, wraps at 16 bits
//   missed_ticks  ticks lost behind a pending request, saturating at 255
//   stalled       watchdog expired (no game_clock rising edge for STALL_CYCLES)
//   state         IDLE=0, RUN=1, PAUSED=2, STALLED=3
//
// Optional feature macro: TICK_HANDSHAKE_EN (undefined = 1-cycle pulse mode).

module game_tick_sync #(
  parameter int STALL_CYCLES = 30_000_000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_clock,
  input  logic        pause,
  input  logic [1:0]  speed_level,
  input  logic        move_ack,
  output logic        move_tick,
  output logic [15:0] tick_count,
  output logic [7:0]  missed_ticks,
  output logic        stalled,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] STALLED = 2'd3;

  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYCLES);
  localparam logic [CNT_W-1:0] WD_ONE    = CNT_W'(1);

  // Synchroniser / edge detector
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic gc_rise;

  // Control state
  logic [1:0]       skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             stalled_q, stalled_d;
  logic [1:0]       state_q, state_d;
  logic             seen_edge_q, seen_edge_d;

  // Output registers
  logic             move_tick_q, move_tick_d;
  logic [15:0]      tick_count_q, tick_count_d;
  logic [7:0]       missed_ticks_q, missed_ticks_d;

  logic [1:0]       tick_thresh;
  logic             tick;

  // ------------------------------------------------------------------
  // game_clock synchroniser; s3 only exists to detect the rising edge.
  // ------------------------------------------------------------------
  always_comb begin
    s1_d = game_clock;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign gc_rise = s2_q & ~s3_q;

  // ------------------------------------------------------------------
  // Speed scaling: an edge issues a tick once skip_cnt has reached the
  // threshold. Comparing with >= (rather than ==) means a speed-up that
  // drops the threshold below the current count ticks on the next edge.
  // Pause wins over a coincident edge and freezes the counter.
  // ------------------------------------------------------------------
  always_comb begin
    tick_thresh = 2'd3 - speed_level;
    tick        = 1'b0;
    skip_cnt_d  = skip_cnt_q;
    if (gc_rise && !pause) begin
      if (skip_cnt_q >= tick_thresh) begin
        tick       = 1'b1;
        skip_cnt_d = 2'd0;
      end else begin
        skip_cnt_d = skip_cnt_q + 2'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Watchdog: free-running in every state, cleared by each rising edge,
  // held once it reaches the limit so stalled stays asserted.
  // ------------------------------------------------------------------
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    stalled_d = 1'b0;
    if (gc_rise) begin
      wd_cnt_d  = '0;
      stalled_d = 1'b0;
    end else begin
      if (wd_cnt_q < STALL_LIM) begin
        wd_cnt_d = wd_cnt_q + WD_ONE;
      end
      stalled_d = (wd_cnt_d >= STALL_LIM);
    end
  end

  // ------------------------------------------------------------------
  // Mode FSM. stalled_d is used (not stalled_q) so state and the stalled
  // output change on the same clock edge.
  // ------------------------------------------------------------------
  always_comb begin
    seen_edge_d = seen_edge_q | gc_rise;
    state_d     = state_q;
    if (pause) begin
      state_d = PAUSED;
    end else begin
      case (state_q)
        IDLE: begin
          if (stalled_d) begin
            state_d = STALLED;
          end else if (gc_rise) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (stalled_d) begin
            state_d = STALLED;
          end
        end
        STALLED: begin
          if (gc_rise) begin
            state_d = RUN;
          end
        end
        PAUSED: begin
          // Leaving pause: an expired watchdog still takes precedence,
          // otherwise resume only if the game clock has ever been seen.
          if (stalled_d) begin
            state_d = STALLED;
          end else if (seen_edge_d) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Tick delivery
  // ------------------------------------------------------------------
`ifdef TICK_HANDSHAKE_EN
  always_comb begin
    move_tick_d    = move_tick_q;
    tick_count_d   = tick_count_q;
    missed_ticks_d = missed_ticks_q;
    if (tick) begin
      if (move_tick_q && !move_ack) begin
        // Request still outstanding: this tick is lost.
        if (missed_ticks_q != 8'hFF) begin
          missed_ticks_d = missed_ticks_q + 8'd1;
        end
      end else begin
        // Idle, or the old request retires this cycle: raise a fresh one.
        move_tick_d  = 1'b1;
        tick_count_d = tick_count_q + 16'd1;
      end
    end else if (move_ack) begin
      move_tick_d = 1'b0;
    end
  end
`else
  logic unused_move_ack;
  assign unused_move_ack = move_ack;

  always_comb begin
    move_tick_d    = tick;
    tick_count_d   = tick_count_q + {15'd0, tick};
    missed_ticks_d = 8'd0;
  end
`endif

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      skip_cnt_q     <= 2'd0;
      wd_cnt_q       <= '0;
      stalled_q      <= 1'b0;
      state_q        <= IDLE;
      seen_edge_q    <= 1'b0;
      move_tick_q    <= 1'b0;
      tick_count_q   <= 16'd0;
      missed_ticks_q <= 8'd0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      skip_cnt_q     <= skip_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      stalled_q      <= stalled_d;
      state_q        <= state_d;
      seen_edge_q    <= seen_edge_d;
      move_tick_q    <= move_tick_d;
      tick_count_q   <= tick_count_d;
      missed_ticks_q <= missed_ticks_d;
    end
  end

  assign move_tick    = move_tick_q;
  assign tick_count   = tick_count_q;
  assign missed_ticks = missed_ticks_q;
  assign stalled      = stalled_q;
  assign state        = state_q;

endmodule

// File: tb/tb_game_tick_sync.sv
// Purpose     : self-checking bench for game_tick_sync (STALL_CYCLES=100,
//               game_clock period 20 clk, 10 high).
// Latency     : n/a
// Backpressure: n/a
module tb_game_tick_sync;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] STALLED = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_clock;
  logic        pause;
  logic [1:0]  speed_level;
  logic        move_ack;
  logic        move_tick;
  logic [15:0] tick_count;
  logic [7:0]  missed_ticks;
  logic        stalled;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  game_tick_sync #(
    .STALL_CYCLES(100),
    .CNT_W       (26)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .game_clock  (game_clock),
    .pause       (pause),
    .speed_level (speed_level),
    .move_ack    (move_ack),
    .move_tick   (move_tick),
    .tick_count  (tick_count),
    .missed_ticks(missed_ticks),
    .stalled     (stalled),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".move_tick"},    32'(move_tick),    32'd0);
    chk({tag, ".tick_count"},   32'(tick_count),   32'd0);
    chk({tag, ".missed_ticks"}, 32'(missed_ticks), 32'd0);
    chk({tag, ".stalled"},      32'(stalled),      32'd0);
    chk({tag, ".state"},        32'(state),        32'(IDLE));
  endtask

  // One full game_clock period (20 clk, high for the first 10). Counts clk
  // cycles in which move_tick is high and the window index of the first one.
  // pause_idx >= 0 drives pause high for exactly that one cycle.
  task automatic edge_window(input int pause_idx, output int ticks, output int first_idx);
    ticks     = 0;
    first_idx = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      game_clock = (i < 10);
      if (pause_idx >= 0) pause = (i == pause_idx);
      @(posedge clk);
      #1;
      if (move_tick === 1'b1) begin
        ticks++;
        if (first_idx < 0) first_idx = i;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    game_clock = 1'b0;
    pause      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] spd;
    bit         pse;
    int         edges;
    int         exp_ticks;
    int         exp_count;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int t, f, total;

    vecs[0]  = '{1, 2'd3, 0, 3, 3, 3, RUN};     // every edge ticks
    vecs[1]  = '{1, 2'd0, 0, 8, 2, 2, RUN};     // 4th and 8th edge
    vecs[2]  = '{1, 2'd1, 0, 6, 2, 2, RUN};     // every 3rd edge
    vecs[3]  = '{1, 2'd2, 0, 4, 2, 2, RUN};     // every 2nd edge
    vecs[4]  = '{1, 2'd0, 0, 2, 0, 0, RUN};     // skip_cnt -> 2
    vecs[5]  = '{0, 2'd2, 0, 1, 1, 1, RUN};     // threshold 1 below count 2
    vecs[6]  = '{0, 2'd0, 0, 2, 0, 1, RUN};     // skip_cnt -> 2
    vecs[7]  = '{0, 2'd0, 1, 5, 0, 1, PAUSED};  // paused, skip_cnt held
    vecs[8]  = '{0, 2'd0, 0, 2, 1, 2, RUN};     // 2 -> 3, then tick
    vecs[9]  = '{1, 2'd3, 1, 2, 0, 0, PAUSED};  // pause from IDLE, edges ignored
    vecs[10] = '{0, 2'd3, 0, 1, 1, 1, RUN};     // resume to RUN (edges seen)
    vecs[11] = '{1, 2'd3, 1, 0, 0, 0, PAUSED};  // pause before any edge
    vecs[12] = '{0, 2'd3, 0, 0, 0, 0, IDLE};    // release -> IDLE
    vecs[13] = '{0, 2'd3, 0, 1, 1, 1, RUN};
    vecs[14] = '{0, 2'd1, 0, 3, 1, 2, RUN};     // speed 1: 3rd edge

    reset       = 1'b1;
    game_clock  = 1'b0;
    pause       = 1'b0;
    speed_level = 2'd3;
    move_ack    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // First-edge latency: tick seen in the cycle after the 3rd sampling edge
    edge_window(-1, t, f);
    chk("latency.first_idx", 32'(f), 32'd2);
    chk("latency.width",     32'(t), 32'd1);
    chk("latency.count",     32'(tick_count), 32'd1);

    // Table-driven vectors
    for (int r = 0; r < 15; r++) begin
      if (vecs[r].rst) do_reset();
      @(negedge clk);
      speed_level = vecs[r].spd;
      pause       = vecs[r].pse;
      total       = 0;
      if (vecs[r].edges == 0) repeat (5) @(negedge clk);
      for (int e = 0; e < vecs[r].edges; e++) begin
        edge_window(-1, t, f);
        total += t;
      end
      chk($sformatf("vec%0d.ticks", r),  32'(total),        32'(vecs[r].exp_ticks));
      chk($sformatf("vec%0d.count", r),  32'(tick_count),   32'(vecs[r].exp_count));
      chk($sformatf("vec%0d.state", r),  32'(state),        32'(vecs[r].exp_state));
      chk($sformatf("vec%0d.missed", r), 32'(missed_ticks), 32'd0);
    end

    // Pause coincident with the edge: no tick, then back to RUN
    do_reset();
    speed_level = 2'd3;
    edge_window(-1, t, f);
    edge_window(2, t, f);
    chk("pause_on_edge.ticks", 32'(t), 32'd0);
    chk("pause_on_edge.count", 32'(tick_count), 32'd1);
    chk("pause_on_edge.state", 32'(state), 32'(RUN));

    // Watchdog from RUN: edge cleared the counter 2 cycles into the window
    do_reset();
    speed_level = 2'd3;
    edge_window(-1, t, f);
    repeat (80) @(posedge clk);
    #1;
    chk("stall.early", 32'(stalled), 32'd0);
    chk("stall.early_state", 32'(state), 32'(RUN));
    repeat (5) @(posedge clk);
    #1;
    chk("stall.set", 32'(stalled), 32'd1);
    chk("stall.state", 32'(state), 32'(STALLED));
    edge_window(-1, t, f);
    chk("stall.clear", 32'(stalled), 32'd0);
    chk("stall.resume", 32'(state), 32'(RUN));

    // Watchdog from IDLE, and while paused
    do_reset();
    repeat (110) @(negedge clk);
    chk("stall_idle.stalled", 32'(stalled), 32'd1);
    chk("stall_idle.state", 32'(state), 32'(STALLED));
    pause = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_paused.stalled", 32'(stalled), 32'd1);
    chk("stall_paused.state", 32'(state), 32'(PAUSED));
    pause = 1'b0;
    edge_window(-1, t, f);
    chk("stall_paused.clear", 32'(stalled), 32'd0);
    chk("stall_paused.resume", 32'(state), 32'(RUN));

    // Reset mid-skip: skip_cnt=2 must be cleared by reset
    do_reset();
    speed_level = 2'd3;
    edge_window(-1, t, f);
    speed_level = 2'd0;
    edge_window(-1, t, f);
    edge_window(-1, t, f);
    chk("mid_skip.pre_count", 32'(tick_count), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_skip");
    @(negedge clk);
    reset = 1'b0;
    total = 0;
    for (int e = 0; e < 3; e++) begin
      edge_window(-1, t, f);
      total += t;
    end
    chk("mid_skip.after_ticks", 32'(total), 32'd0);

    // Reset while a tick is on the output: asynchronous, pending tick dropped
    do_reset();
    speed_level = 2'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      game_clock = (i < 10);
      @(posedge clk);
      #1;
      if (i == 2) begin
        chk("mid_req.pre_tick", 32'(move_tick), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("mid_req");
      end
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_req.after_count", 32'(tick_count), 32'd0);
    chk("mid_req.after_tick", 32'(move_tick), 32'd0);

`ifdef TICK_HANDSHAKE_EN
    // Request held without ack; later ticks counted as missed
    do_reset();
    speed_level = 2'd3;
    move_ack    = 1'b0;
    for (int e = 0; e < 3; e++) edge_window(-1, t, f);
    chk("hs.held", 32'(move_tick), 32'd1);
    chk("hs.missed", 32'(missed_ticks), 32'd2);
    chk("hs.count", 32'(tick_count), 32'd1);
    @(negedge clk);
    move_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("hs.retired", 32'(move_tick), 32'd0);
    chk("hs.count_after", 32'(tick_count), 32'd1);
`else
    // Pulse mode ignores move_ack entirely
    do_reset();
    speed_level = 2'd3;
    move_ack    = 1'b0;
    total       = 0;
    for (int e = 0; e < 3; e++) begin
      edge_window(-1, t, f);
      total += t;
    end
    chk("noack.ticks", 32'(total), 32'd3);
    chk("noack.count", 32'(tick_count), 32'd3);
    chk("noack.missed", 32'(missed_ticks), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
